// File: rtl/generador_frecuencia_pkg.sv
// Shared definitions for the square-wave frequency generator: setting width,
// the fastest legal setting, FSM states and the setting/half-period helpers.
package generador_frecuencia_pkg;

    localparam int SETTING_W = 4;
    localparam logic [SETTING_W-1:0] SETTING_MAX = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

    // Clamp a raw selector value into the legal 0..SETTING_MAX range.
    function automatic logic [SETTING_W-1:0] sat(input logic [SETTING_W-1:0] n);
        return (n > SETTING_MAX) ? SETTING_MAX : n;
    endfunction

    // Half-period in clock cycles for setting n: each step up halves it.
    function automatic logic [31:0] half_period(input logic [31:0] div0,
                                                input logic [SETTING_W-1:0] n);
        return div0 >> n;
    endfunction

endpackage

// File: rtl/contador_medio_periodo.sv
// Half-period counter: counts up to a programmable limit, flags the terminal
// count and wraps to zero there, and can be cleared synchronously at any time.
module contador_medio_periodo #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         avanzar,
    input  logic [W-1:0] limite,
    output logic         terminal
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign terminal = (cnt_q == limite);

    // Next count: clear wins, otherwise advance and wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (avanzar) begin
            if (terminal) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/generador_frecuencia.sv
// Square-wave generator with 9 selectable frequencies. The applied setting is
// only refreshed at the end of a full period so a mid-period change on bf never
// produces a runt half-period; tick marks each rising edge of onda.
module generador_frecuencia
    import generador_frecuencia_pkg::*;
#(
    parameter int unsigned DIV0 = 25_000_000,
    parameter int          W    = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [SETTING_W-1:0] bf,
    output logic                 onda,
    output logic                 tick,
    output logic [SETTING_W-1:0] bf_activo,
    output logic                 cambio,
    output logic                 fuera_rango
);

    estado_t              estado_q, estado_d;
    logic                 onda_q, onda_d;
    logic                 tick_q, tick_d;
    logic [SETTING_W-1:0] bf_activo_q, bf_activo_d;
    logic                 cambio_q, cambio_d;
    logic                 fuera_rango_q, fuera_rango_d;

    logic [31:0]          medio;
    logic [W-1:0]         limite;
    logic                 terminal;
    logic                 avanzar;
    logic                 limpiar;
    logic [SETTING_W-1:0] bf_sat;

    assign bf_sat  = sat(bf);
    assign medio   = half_period(DIV0, bf_activo_q);
    assign limite  = W'(medio - 32'd1);
    assign avanzar = (estado_q == RUN) && enable;
    assign limpiar = (estado_q != RUN) || !enable;

    contador_medio_periodo #(
        .W (W)
    ) u_contador (
        .clk      (clk),
        .rst      (rst),
        .clear    (limpiar),
        .avanzar  (avanzar),
        .limite   (limite),
        .terminal (terminal)
    );

    // Next-state and next-output logic for the IDLE/RUN controller.
    always_comb begin
        estado_d      = estado_q;
        onda_d        = onda_q;
        tick_d        = 1'b0;
        cambio_d      = 1'b0;
        bf_activo_d   = bf_activo_q;
        fuera_rango_d = (bf > SETTING_MAX);
        case (estado_q)
            IDLE: begin
                onda_d = 1'b0;
                if (enable) begin
                    estado_d    = RUN;
                    bf_activo_d = bf_sat;
                    cambio_d    = (bf_sat != bf_activo_q);
                end
            end
            RUN: begin
                if (!enable) begin
                    estado_d = IDLE;
                    onda_d   = 1'b0;
                end else if (terminal) begin
                    onda_d = ~onda_q;
                    if (!onda_q) begin
                        tick_d = 1'b1;
                    end else begin
                        bf_activo_d = bf_sat;
                        cambio_d    = (bf_sat != bf_activo_q);
                    end
                end
            end
            default: begin
                estado_d = IDLE;
                onda_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q      <= IDLE;
            onda_q        <= 1'b0;
            tick_q        <= 1'b0;
            bf_activo_q   <= '0;
            cambio_q      <= 1'b0;
            fuera_rango_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            onda_q        <= onda_d;
            tick_q        <= tick_d;
            bf_activo_q   <= bf_activo_d;
            cambio_q      <= cambio_d;
            fuera_rango_q <= fuera_rango_d;
        end
    end

    assign onda        = onda_q;
    assign tick        = tick_q;
    assign bf_activo   = bf_activo_q;
    assign cambio      = cambio_q;
    assign fuera_rango = fuera_rango_q;

endmodule

// File: tb/tb_generador_frecuencia.sv
// Testbench for generador_frecuencia: directed scenarios plus randomized
// traffic, every cycle compared against a period-position reference model.
module tb_generador_frecuencia;

    localparam int DIV0 = 256;
    localparam int W    = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] bf;
    logic       onda;
    logic       tick;
    logic [3:0] bf_activo;
    logic       cambio;
    logic       fuera_rango;

    int total = 0;
    int bad   = 0;

    // Reference model: position inside the full period and the applied setting.
    int m_run = 0;
    int m_pos = 0;
    int m_act = 0;
    bit m_onda = 1'b0;
    bit m_tick = 1'b0;
    bit m_cambio = 1'b0;
    bit m_fr = 1'b0;

    generador_frecuencia #(
        .DIV0 (DIV0),
        .W    (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bf          (bf),
        .onda        (onda),
        .tick        (tick),
        .bf_activo   (bf_activo),
        .cambio      (cambio),
        .fuera_rango (fuera_rango)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task modelStep;
        int s;
        int h;
        s = (int'(bf) > 8) ? 8 : int'(bf);
        m_tick   = 1'b0;
        m_cambio = 1'b0;
        if (rst) begin
            m_run = 0; m_pos = 0; m_act = 0; m_onda = 1'b0; m_fr = 1'b0;
        end else begin
            m_fr = (int'(bf) > 8);
            if (m_run == 0) begin
                if (enable) begin
                    m_run = 1; m_pos = 0; m_onda = 1'b0;
                    m_cambio = (s != m_act);
                    m_act = s;
                end
            end else if (!enable) begin
                m_run = 0; m_pos = 0; m_onda = 1'b0;
            end else begin
                h = DIV0 / (1 << m_act);
                m_pos = m_pos + 1;
                if (m_pos == h) begin
                    m_onda = 1'b1;
                    m_tick = 1'b1;
                end else if (m_pos == 2 * h) begin
                    m_pos = 0;
                    m_onda = 1'b0;
                    m_cambio = (s != m_act);
                    m_act = s;
                end
            end
        end
    endtask

    task checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task checkOutput;
        checkValue("onda", {3'b000, onda}, {3'b000, m_onda});
        checkValue("tick", {3'b000, tick}, {3'b000, m_tick});
        checkValue("cambio", {3'b000, cambio}, {3'b000, m_cambio});
        checkValue("fuera_rango", {3'b000, fuera_rango}, {3'b000, m_fr});
        checkValue("bf_activo", bf_activo, 4'(m_act));
    endtask

    task applyStimulus(input logic r, input logic e, input logic [3:0] b);
        rst    = r;
        enable = e;
        bf     = b;
    endtask

    task stepCycle;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    // Advance until the model has applied setting s, bounded by maxCycles.
    task waitActive(input int s, input int maxCycles, input string tag);
        bit ok;
        ok = (m_act == s);
        for (int i = 0; i < maxCycles && !ok; i++) begin
            stepCycle();
            ok = (m_act == s);
        end
        checkValue(tag, {3'b000, ok}, 4'd1);
    endtask

    // Advance until the model's onda is high, bounded by maxCycles.
    task waitHigh(input int maxCycles, input string tag);
        bit ok;
        ok = m_onda;
        for (int i = 0; i < maxCycles && !ok; i++) begin
            stepCycle();
            ok = m_onda;
        end
        checkValue(tag, {3'b000, ok}, 4'd1);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int highs;
        int ticks;
        int cambios;
        int riseAt;

        // Reset state
        applyStimulus(1'b1, 1'b0, 4'd0);
        stepCycle();
        stepCycle();
        checkValue("reset_onda", {3'b000, onda}, 4'd0);
        checkValue("reset_bf_activo", bf_activo, 4'd0);

        // Fastest setting: onda toggles every cycle, tick on each rise
        applyStimulus(1'b0, 1'b1, 4'd8);
        stepCycle();
        checkValue("entry_onda", {3'b000, onda}, 4'd0);
        checkValue("entry_cambio", {3'b000, cambio}, 4'd1);
        stepCycle();
        checkValue("fast_rise_onda", {3'b000, onda}, 4'd1);
        checkValue("fast_rise_tick", {3'b000, tick}, 4'd1);
        stepCycle();
        checkValue("fast_fall_tick", {3'b000, tick}, 4'd0);
        for (int i = 0; i < 8; i++) stepCycle();

        // Slowest setting: 512-cycle period with 256 high, one tick per period
        applyStimulus(1'b0, 1'b1, 4'd0);
        waitActive(0, 10, "load_setting0");
        highs = 0;
        ticks = 0;
        for (int i = 0; i < 1024; i++) begin
            stepCycle();
            highs += int'(onda);
            ticks += int'(tick);
        end
        checkValue("slow_high_cycles_div64", 4'(highs / 64), 4'd8);
        checkValue("slow_tick_count", 4'(ticks), 4'd2);

        // Setting change during the high phase takes effect only at period end
        applyStimulus(1'b0, 1'b1, 4'd2);
        waitActive(2, 600, "load_setting2");
        waitHigh(100, "setting2_high");
        for (int i = 0; i < 10; i++) stepCycle();
        applyStimulus(1'b0, 1'b1, 4'd5);
        cambios = 0;
        for (int i = 0; i < 60; i++) begin
            stepCycle();
            cambios += int'(cambio);
        end
        checkValue("change_2to5_cambios", 4'(cambios), 4'd1);
        checkValue("change_2to5_active", bf_activo, 4'd5);
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            stepCycle();
            highs += int'(onda);
        end
        checkValue("setting5_high_div4", 4'(highs / 4), 4'd8);

        // Out-of-range selector clamps to the fastest setting
        applyStimulus(1'b0, 1'b1, 4'd12);
        stepCycle();
        checkValue("fuera_rango_set", {3'b000, fuera_rango}, 4'd1);
        waitActive(8, 40, "load_clamped8");
        for (int i = 0; i < 6; i++) stepCycle();

        // Enable drop mid-period, then first rise HALF cycles after re-entry
        applyStimulus(1'b0, 1'b1, 4'd3);
        waitActive(3, 10, "load_setting3");
        for (int i = 0; i < 20; i++) stepCycle();
        applyStimulus(1'b0, 1'b0, 4'd3);
        stepCycle();
        checkValue("disable_onda", {3'b000, onda}, 4'd0);
        checkValue("disable_tick", {3'b000, tick}, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd3);
        stepCycle();
        riseAt = 0;
        for (int k = 1; k <= 40 && riseAt == 0; k++) begin
            stepCycle();
            if (tick) riseAt = k;
        end
        checkValue("reenable_rise_div4", 4'(riseAt / 4), 4'd8);

        // Reset while onda is high
        waitHigh(40, "pre_reset_high");
        applyStimulus(1'b1, 1'b1, 4'd3);
        stepCycle();
        checkValue("rst_run_onda", {3'b000, onda}, 4'd0);
        checkValue("rst_run_bf_activo", bf_activo, 4'd0);
        checkValue("rst_run_cambio", {3'b000, cambio}, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd3);
        stepCycle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [3:0] nb;
            r  = int'($urandom_range(0, 99));
            nb = bf;
            if ($urandom_range(0, 9) == 0) nb = 4'($urandom_range(0, 15));
            if (nb < 4'd4) nb = nb + 4'd4;
            applyStimulus(r < 2, r >= 8, nb);
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/generador_frecuencia.md
GENERADOR_FRECUENCIA -- requirements
Module: generador_frecuencia

Interface
REQ-001 Parameter DIV0, default 25_000_000, half-period in clk cycles for setting 0; SHALL be >= 256.
REQ-002 Parameter W, default 25, width of the half-period counter; SHALL hold DIV0-1.
REQ-003 clk  input  1  system clock; the block SHALL have one clock, with all state updated on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  mode select; generation runs only while high.
REQ-006 bf  input  4  frequency setting from the up/down selector, legal range 0..8.
REQ-007 onda  output  1  50% duty square wave.
REQ-008 tick  output  1  one-cycle pulse coincident with each rising edge of onda.
REQ-009 bf_activo  output  4  setting currently applied to onda.
REQ-010 cambio  output  1  one-cycle pulse when bf_activo changes value.
REQ-011 fuera_rango  output  1  registered flag: bf sampled last cycle was > 8.

Function
REQ-012 Half-period for setting n SHALL be HALF(n) = DIV0 >> n, so setting 8 is the fastest and 0 the slowest; full period is 2*HALF(n) cycles.
REQ-013 The effective setting sat(bf) SHALL be min(bf, 8).
REQ-014 fuera_rango SHALL be updated every cycle to (bf > 8), independent of enable.
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 IDLE: cnt=0, onda=0, tick=0, cambio=0; when enable=1, the next state SHALL be RUN, with cnt<=0, onda<=0, and bf_activo<=sat(bf).
REQ-017 On the IDLE->RUN entry, cambio SHALL pulse only if the loaded value differs from the previous bf_activo.
REQ-018 RUN, enable=1, cnt < HALF(bf_activo)-1: cnt SHALL increment, and onda SHALL hold.
REQ-019 RUN, enable=1, cnt == HALF(bf_activo)-1: cnt<=0 and onda<=~onda.
REQ-020 If onda was 0 at the REQ-019 boundary, tick<=1 in the same cycle that onda rises.
REQ-021 If onda was 1 at the REQ-019 boundary (period end), bf_activo<=sat(bf), with cambio<=1 if the value differs.
REQ-022 Changes to bf mid-period SHALL NOT affect the current period, so no runt half-periods occur.
REQ-023 RUN, enable=0: the next state SHALL be IDLE, with onda<=0, cnt<=0, and tick=0 on that edge, regardless of cnt or the onda phase.
REQ-024 bf_activo SHALL hold its value in IDLE.
REQ-025 tick and cambio SHALL be single-cycle pulses that are 0 on every edge not named above.
REQ-026 The first rising edge of onda SHALL occur HALF(bf_activo) cycles after the RUN-entry edge.
REQ-027 Counter arithmetic SHALL be unsigned W bits and SHALL never exceed HALF-1, so no wrap-around is possible.

Reset
REQ-028 When rst=1 on an edge, the next state SHALL be IDLE, with cnt=0, onda=0, tick=0, cambio=0, bf_activo=0, and fuera_rango=0.
REQ-029 rst SHALL take priority over enable and over all boundary events, including a reset that arrives mid-period.
REQ-030 After rst deasserts with enable=1, the block SHALL enter RUN on the first non-reset edge per REQ-016.

Structure
REQ-031 A shared package SHALL hold SETTING_MAX=4'd8 and the setting width (4).
REQ-032 The shared package SHALL hold the sat() clamp function and the half_period(n) function.
REQ-033 One sub-module, contador_medio_periodo, SHALL implement the cnt register, terminal-count detect, and synchronous clear.
REQ-034 The FSM and output registers SHALL reside in generador_frecuencia.

Verification
REQ-035 DIV0=256, bf=8, enable rises -> RUN next edge; onda toggles every cycle (HALF=1), and tick is high every 2nd cycle aligned with onda rising.
REQ-036 DIV0=256, bf=0 -> onda period 512 cycles with exactly 256 high; one tick per period.
REQ-037 bf changes 2->5 mid-high-phase -> the current period completes at HALF=64, bf_activo=5 at the falling edge, cambio pulses once, and the next period is 16 cycles.
REQ-038 bf=12 -> fuera_rango=1 the next cycle, bf_activo=8 at the next period end, and onda runs at HALF=1.
REQ-039 enable drops mid-period -> onda=0 and cnt=0 the next cycle with no tick; on re-enable, the first onda rise occurs HALF cycles later.
REQ-040 rst asserted in RUN with onda=1 -> all outputs 0 and bf_activo=0 on the next edge; no tick or cambio is produced.
